// File: rtl/regfile_param_if.sv
// Register file access bundle: decode-side read addresses, writeback-side write port,
// clear request and the combinational read data / busy status coming back.
interface regfile_param_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  writeOrder;
    logic [ADDR_WIDTH-1:0] writeAddr;
    logic [DATA_WIDTH-1:0] writeData;
    logic [ADDR_WIDTH-1:0] readAddr1;
    logic [ADDR_WIDTH-1:0] readAddr2;
    logic                  clearReq;
    logic [DATA_WIDTH-1:0] readData1;
    logic [DATA_WIDTH-1:0] readData2;
    logic                  busy;

    modport master (
        output writeOrder, writeAddr, writeData, readAddr1, readAddr2, clearReq,
        input  readData1, readData2, busy
    );

    modport slave (
        input  writeOrder, writeAddr, writeData, readAddr1, readAddr2, clearReq,
        output readData1, readData2, busy
    );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with write bypass and a zeroing clear engine; optional REGFILE_ZERO_REG_EN hardwires entry 0 to zero.
// Latency: reads combinational (zero cycles), writes commit on the rising edge; a clear takes 2**ADDR_WIDTH cycles.
// Backpressure: none; while busy writes and clear requests are dropped and reads return zero.
module regfile_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter bit BYPASS     = 1'b1
) (
    input  logic            clock,
    input  logic            resetN,
    regfile_param_if.slave  rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t                state;
    state_t                nextState;
    logic [ADDR_WIDTH-1:0] clrPtr;
    logic [ADDR_WIDTH-1:0] nextPtr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  writeEn;

    always_ff @(posedge clock) begin
        if (!resetN) begin
            state  <= CLEAR;
            clrPtr <= '0;
        end else begin
            state  <= nextState;
            clrPtr <= nextPtr;
        end
    end

    always_comb begin
        nextState = state;
        nextPtr   = clrPtr;
        case (state)
            IDLE: begin
                if (rf.clearReq) begin
                    nextState = CLEAR;
                end
            end
            CLEAR: begin
                // pointer wraps naturally to 0 on the last entry
                nextPtr = clrPtr + ADDR_WIDTH'(1);
                if (clrPtr == ADDR_WIDTH'(DEPTH - 1)) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = CLEAR;
                nextPtr   = '0;
            end
        endcase
    end

    assign writeEn = (state == IDLE) && rf.writeOrder &&
                     !(ZERO_REG && (rf.writeAddr == '0));

    // Array has no reset of its own; the clear engine is what zeroes it.
    always_ff @(posedge clock) begin
        if (resetN) begin
            if (state == CLEAR) begin
                mem[clrPtr] <= '0;
            end else if (writeEn) begin
                mem[rf.writeAddr] <= rf.writeData;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] readPort(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] data;
        data = mem[addr];
        if (state != IDLE) begin
            data = '0;
        end else if (ZERO_REG && (addr == '0)) begin
            data = '0;
        end else if (BYPASS && rf.writeOrder && (addr == rf.writeAddr)) begin
            data = rf.writeData;
        end
        return data;
    endfunction

    always_comb begin
        rf.readData1 = readPort(rf.readAddr1);
        rf.readData2 = readPort(rf.readAddr2);
    end

    assign rf.busy = (state == CLEAR);
endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: one bypassing and one non-bypassing instance driven in lockstep.
module tb_regfile_param;
    logic        clock;
    logic        resetN;
    logic        writeOrder;
    logic [2:0]  writeAddr;
    logic [15:0] writeData;
    logic [2:0]  readAddr1;
    logic [2:0]  readAddr2;
    logic        clearReq;

    int nChecks = 0;
    int nFail   = 0;

    regfile_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ifA ();
    regfile_param_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) ifB ();

    assign ifA.writeOrder = writeOrder;
    assign ifA.writeAddr  = writeAddr;
    assign ifA.writeData  = writeData;
    assign ifA.readAddr1  = readAddr1;
    assign ifA.readAddr2  = readAddr2;
    assign ifA.clearReq   = clearReq;
    assign ifB.writeOrder = writeOrder;
    assign ifB.writeAddr  = writeAddr;
    assign ifB.writeData  = writeData;
    assign ifB.readAddr1  = readAddr1;
    assign ifB.readAddr2  = readAddr2;
    assign ifB.clearReq   = clearReq;

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1'b1)) dutA (
        .clock (clock),
        .resetN(resetN),
        .rf    (ifA.slave)
    );

    regfile_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1'b0)) dutB (
        .clock (clock),
        .resetN(resetN),
        .rf    (ifB.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        wo;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [15:0] expA1;
        logic [15:0] expA2;
        logic [15:0] expB1;
        logic [15:0] expB2;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
        #1;
    endtask

    // Counts cycles with busy high, sampled between edges, bounded at 20.
    task automatic countBusy(output int nA, output int nB);
        int guard;
        nA = 0;
        nB = 0;
        guard = 0;
        while ((ifA.busy === 1'b1 || ifB.busy === 1'b1) && guard < 20) begin
            if (ifA.busy === 1'b1) nA++;
            if (ifB.busy === 1'b1) nB++;
            guard++;
            step();
        end
    endtask

    task automatic checkAllZero(input string name);
        for (int i = 0; i < 8; i++) begin
            readAddr1 = 3'(i);
            readAddr2 = 3'(7 - i);
            #1;
            check({name, "_A1"}, ifA.readData1, 16'h0000);
            check({name, "_A2"}, ifA.readData2, 16'h0000);
            check({name, "_B1"}, ifB.readData1, 16'h0000);
        end
    endtask

    initial begin
        int nA;
        int nB;
        int n;

        //         wo    wa    wd        ra1   ra2   expA1     expA2     expB1     expB2
        vecs[0] = '{1'b1, 3'd5, 16'hBEEF, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[1] = '{1'b0, 3'd0, 16'h0000, 3'd5, 3'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF};
        vecs[2] = '{1'b1, 3'd7, 16'h1234, 3'd5, 3'd7, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h0000};
        vecs[3] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd5, 16'h1234, 16'hBEEF, 16'h1234, 16'hBEEF};
        vecs[4] = '{1'b1, 3'd3, 16'h0001, 3'd3, 3'd0, 16'h0001, 16'h0000, 16'h0000, 16'h0000};
        vecs[5] = '{1'b1, 3'd3, 16'hA5A5, 3'd3, 3'd3, 16'hA5A5, 16'hA5A5, 16'h0001, 16'h0001};
        vecs[6] = '{1'b0, 3'd0, 16'h0000, 3'd3, 3'd5, 16'hA5A5, 16'hBEEF, 16'hA5A5, 16'hBEEF};
        vecs[7] = '{1'b1, 3'd1, 16'h0BAD, 3'd1, 3'd3, 16'h0BAD, 16'hA5A5, 16'h0000, 16'hA5A5};
        vecs[8] = '{1'b0, 3'd0, 16'h0000, 3'd1, 3'd7, 16'h0BAD, 16'h1234, 16'h0BAD, 16'h1234};

        resetN     = 1'b0;
        writeOrder = 1'b0;
        writeAddr  = '0;
        writeData  = '0;
        readAddr1  = '0;
        readAddr2  = '0;
        clearReq   = 1'b0;

        // Reset: busy and forced-zero reads while held, then an 8-cycle clear
        step();
        step();
        check("rst_busyA", {15'd0, ifA.busy}, 16'd1);
        check("rst_rdA1", ifA.readData1, 16'h0000);
        check("rst_rdB2", ifB.readData2, 16'h0000);
        resetN = 1'b1;
        countBusy(nA, nB);
        check("rst_busy_cyclesA", 16'(nA), 16'd8);
        check("rst_busy_cyclesB", 16'(nB), 16'd8);
        checkAllZero("rst_zero");

        // Table: write/read, bypass vs non-bypass
        for (int i = 0; i < 9; i++) begin
            writeOrder = vecs[i].wo;
            writeAddr  = vecs[i].wa;
            writeData  = vecs[i].wd;
            readAddr1  = vecs[i].ra1;
            readAddr2  = vecs[i].ra2;
            #1;
            check($sformatf("vec%0d_A1", i), ifA.readData1, vecs[i].expA1);
            check($sformatf("vec%0d_A2", i), ifA.readData2, vecs[i].expA2);
            check($sformatf("vec%0d_B1", i), ifB.readData1, vecs[i].expB1);
            check($sformatf("vec%0d_B2", i), ifB.readData2, vecs[i].expB2);
            step();
        end
        writeOrder = 1'b0;

        // Clear request over a full array, with dropped writes and an ignored re-request
        for (int i = 0; i < 8; i++) begin
            writeOrder = 1'b1;
            writeAddr  = 3'(i);
            writeData  = 16'hFFFF;
            step();
        end
        writeOrder = 1'b0;
        readAddr1  = 3'd6;
        #1;
        check("fill_A", ifA.readData1, 16'hFFFF);
        check("fill_B", ifB.readData1, 16'hFFFF);
        clearReq = 1'b1;
        step();
        clearReq = 1'b0;
        n = 0;
        while (ifA.busy === 1'b1 && n < 20) begin
            n++;
            writeOrder = 1'b0;
            clearReq   = (n == 5);
            if (n == 3) begin
                writeOrder = 1'b1;
                writeAddr  = 3'd2;
                writeData  = 16'h5555;
                readAddr1  = 3'd2;
                #1;
                check("clr_rd_forced0", ifA.readData1, 16'h0000);
            end
            if (n == 4) begin
                writeOrder = 1'b1;
                writeAddr  = 3'd1;
                writeData  = 16'h5555;
            end
            step();
        end
        writeOrder = 1'b0;
        clearReq   = 1'b0;
        check("clr_busy_cycles", 16'(n), 16'd8);
        checkAllZero("clr_zero");

        // Reset in the 4th cycle of a clear restarts it from entry 0
        clearReq = 1'b1;
        step();
        clearReq = 1'b0;
        n = 0;
        while (ifA.busy === 1'b1 && n < 4) begin
            n++;
            if (n == 4) resetN = 1'b0;
            step();
        end
        resetN = 1'b1;
        countBusy(nA, nB);
        check("midrst_busy_cyclesA", 16'(nA), 16'd8);
        check("midrst_busy_cyclesB", 16'(nB), 16'd8);

        // Entry 0: hardwired zero when the feature is built in, ordinary otherwise
        writeOrder = 1'b1;
        writeAddr  = 3'd0;
        writeData  = 16'h7777;
        readAddr1  = 3'd0;
        readAddr2  = 3'd1;
        #1;
`ifdef REGFILE_ZERO_REG_EN
        check("r0_same_A", ifA.readData1, 16'h0000);
`else
        check("r0_same_A", ifA.readData1, 16'h7777);
`endif
        check("r0_same_B", ifB.readData1, 16'h0000);
        step();
        writeAddr = 3'd1;
        writeData = 16'h1111;
        #1;
        check("r1_same_A", ifA.readData2, 16'h1111);
        check("r1_same_B", ifB.readData2, 16'h0000);
        step();
        writeOrder = 1'b0;
        #1;
`ifdef REGFILE_ZERO_REG_EN
        check("r0_after_A", ifA.readData1, 16'h0000);
        check("r0_after_B", ifB.readData1, 16'h0000);
`else
        check("r0_after_A", ifA.readData1, 16'h7777);
        check("r0_after_B", ifB.readData1, 16'h7777);
`endif
        check("r1_after_A", ifA.readData2, 16'h1111);
        check("r1_after_B", ifB.readData2, 16'h1111);
        check("idle_busy", {15'd0, ifA.busy}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
